// File: rtl/systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// systolic_tile_scheduler
//
// Sequences one matrix-multiply tile through a ROW_NUM x COL_NUM
// output-stationary systolic array:
//   IDLE -> CLEAR (one-cycle accumulator clear) -> COMPUTE (skewed operand
//   reads for T_LAST+1 productive cycles) -> OUTPUT (one result row per
//   ready/valid handshake) -> DONE (one-cycle completion pulse) -> IDLE.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; aborts a tile with no done
//   start        tile request, sampled only in IDLE
//   stall        operand buffers not ready; freezes COMPUTE for that cycle
//   busy         high in every state except IDLE
//   acc_clear    one-cycle accumulator clear pulse
//   pe_en        array MAC/shift enable
//   a_rd_en      per-row A buffer read enable
//   a_rd_addr    per-row A address, row r at [r*ADDR_W +: ADDR_W]
//   b_rd_en      per-column B buffer read enable
//   b_rd_addr    per-column B address, same packing
//   out_valid    result row available
//   out_row      row index being unloaded
//   out_ready    downstream accepts the current result row
//   done         one-cycle pulse at tile completion
//   stall_cycles (only with `define STALL_CNT_EN) saturating count of stalled
//                COMPUTE cycles in the current/last tile
//
// Optional feature macro: STALL_CNT_EN
//
// All outputs are decoded from registered state (state, t, row). The only
// input that reaches an output in the same cycle is stall, which masks the
// read enables and pe_en so a stalled cycle issues nothing.
// -----------------------------------------------------------------------------
module systolic_tile_scheduler #(
  parameter int ROW_NUM = 4,
  parameter int COL_NUM = 4,
  parameter int K_DEPTH = 4,
  parameter int ADDR_W  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         stall,
  output logic                                         busy,
  output logic                                         acc_clear,
  output logic                                         pe_en,
  output logic [ROW_NUM-1:0]                           a_rd_en,
  output logic [ROW_NUM*ADDR_W-1:0]                    a_rd_addr,
  output logic [COL_NUM-1:0]                           b_rd_en,
  output logic [COL_NUM*ADDR_W-1:0]                    b_rd_addr,
  output logic                                         out_valid,
  output logic [(ROW_NUM > 1 ? $clog2(ROW_NUM) : 1)-1:0] out_row,
  input  logic                                         out_ready,
  output logic                                         done
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]                                  stall_cycles
`endif
);

  // Last compute cycle index: the wavefront has reached the far corner PE
  // and that PE has performed its K_DEPTH-th MAC.
  localparam int T_LAST = K_DEPTH + ROW_NUM + COL_NUM - 3;
  localparam int T_W    = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;
  localparam int ROW_W  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [T_W-1:0]   t, t_nxt;
  logic [ROW_W-1:0] row, row_nxt;

  // Stream idx (row or column) is active while idx <= t < idx + K_DEPTH.
  function automatic logic in_window(input logic [T_W-1:0] tt, input int idx);
    return (int'(tt) >= idx) && (int'(tt) < idx + K_DEPTH);
  endfunction

  // Skewed address t - idx; only used inside the window, so never negative.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [T_W-1:0] tt,
                                                input int idx);
    return ADDR_W'(int'(tt) - idx);
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      t     <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      row   <= row_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    row_nxt   = row;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_COMPUTE;
        t_nxt     = '0;
      end
      S_COMPUTE: begin
        // A stalled cycle holds t so the schedule resumes exactly where it
        // stopped.
        if (!stall) begin
          if (t == T_W'(T_LAST)) begin
            state_nxt = S_OUTPUT;
            row_nxt   = '0;
          end else begin
            t_nxt = t + T_W'(1);
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (row == ROW_W'(ROW_NUM - 1)) state_nxt = S_DONE;
          else                            row_nxt   = row + ROW_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
        row_nxt   = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
        row_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic computing;

  assign computing = (state == S_COMPUTE);
  assign busy      = (state != S_IDLE);
  assign acc_clear = (state == S_CLEAR);
  assign pe_en     = computing && !stall;
  assign out_valid = (state == S_OUTPUT);
  assign out_row   = out_valid ? row : '0;
  assign done      = (state == S_DONE);

  // Addresses follow t even on a stalled cycle (t is frozen, so they hold);
  // only the enables are masked by stall.
  always_comb begin
    a_rd_en   = '0;
    a_rd_addr = '0;
    for (int r = 0; r < ROW_NUM; r++) begin
      if (computing && in_window(t, r)) begin
        a_rd_en[r]                     = !stall;
        a_rd_addr[r*ADDR_W +: ADDR_W] = addr_of(t, r);
      end
    end
  end

  always_comb begin
    b_rd_en   = '0;
    b_rd_addr = '0;
    for (int c = 0; c < COL_NUM; c++) begin
      if (computing && in_window(t, c)) begin
        b_rd_en[c]                     = !stall;
        b_rd_addr[c*ADDR_W +: ADDR_W] = addr_of(t, c);
      end
    end
  end

`ifdef STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall cycle counter: zeroed on entry to CLEAR so it already reads 0 in
  // the CLEAR cycle, then holds after DONE until the next tile starts.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cycles <= '0;
    end else if (computing && stall && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_tile_scheduler (default parameters).
// Stimulus for each scenario is laid out as per-cycle tables (start, stall,
// out_ready, rst). A reference model derives the expected per-cycle outputs
// directly from the tile timeline: start seen in an idle cycle -> one clear
// cycle -> T_LAST+1 productive compute cycles (stalled cycles inserted) ->
// one cycle per result row until accepted -> one done cycle.
// -----------------------------------------------------------------------------
module tb_systolic_tile_scheduler;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KD     = 4;
  localparam int AW     = 4;
  localparam int T_LAST = KD + ROWS + COLS - 3;
  localparam int NMAX   = 64;

  logic        clk = 1'b0;
  logic        rst, start, stall, out_ready;
  logic        busy, acc_clear, pe_en, out_valid, done;
  logic [3:0]  a_rd_en, b_rd_en;
  logic [15:0] a_rd_addr, b_rd_addr;
  logic [1:0]  out_row;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  systolic_tile_scheduler #(
    .ROW_NUM(ROWS), .COL_NUM(COLS), .K_DEPTH(KD), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .acc_clear(acc_clear), .pe_en(pe_en),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .out_valid(out_valid), .out_row(out_row), .out_ready(out_ready),
    .done(done)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Stimulus tables
  bit start_v [NMAX];
  bit stall_v [NMAX];
  bit ready_v [NMAX];
  bit rst_v   [NMAX];

  // Expected per cycle: {busy,acc_clear,pe_en,out_valid,done,a_en,b_en,row}
  logic [14:0] e_vec  [NMAX];
  logic [31:0] e_addr [NMAX];   // {a_rd_addr, b_rd_addr}
  bit          e_chk  [NMAX];   // addresses compared only on unstalled cycles
  logic [15:0] e_scnt [NMAX];
  int          e_dones;

  // Observed per cycle
  logic [14:0] o_vec  [NMAX];
  logic [31:0] o_addr [NMAX];
  logic [15:0] o_scnt [NMAX];
  int          o_dones;
  int          o_first_done;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [14:0] pack_ctrl(bit b, bit c, bit p, bit v, bit d,
                                            logic [3:0] ae, logic [3:0] be,
                                            int r);
    logic [1:0] rr;
    rr = 2'(r);
    return {b, c, p, v, d, ae, be, rr};
  endfunction

  task automatic model_compute(input int p, input int k, input bit stl);
    logic [3:0]  en;
    logic [15:0] ad;
    en = '0;
    ad = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (k >= i && k < i + KD) begin
        en[i]        = !stl;
        ad[i*4 +: 4] = 4'(k - i);
      end
    end
    e_vec[p]  = pack_ctrl(1, 0, !stl, 0, 0, en, en, 0);
    e_addr[p] = {ad, ad};
    e_chk[p]  = !stl;
  endtask

  task automatic build_model(input int n);
    int c, p, k, r;
    bit ab;
    logic [15:0] sc;
    for (int i = 0; i < n; i++) begin
      e_vec[i]  = '0;
      e_addr[i] = '0;
      e_chk[i]  = 1'b1;
    end
    e_dones = 0;
    sc = '0;
    c  = 0;
    while (c < n) begin
      e_scnt[c] = sc;
      if (rst_v[c] || !start_v[c]) begin
        if (rst_v[c]) sc = '0;
        c++;
      end else begin
        p  = c + 1;
        ab = 0;
        if (p < n) begin
          sc        = '0;
          e_vec[p]  = pack_ctrl(1, 1, 0, 0, 0, 4'h0, 4'h0, 0);
          e_scnt[p] = sc;
          ab        = rst_v[p];
          p++;
        end
        k = 0;
        while (!ab && k <= T_LAST && p < n) begin
          model_compute(p, k, stall_v[p]);
          e_scnt[p] = sc;
          if (rst_v[p])          ab = 1;
          else if (stall_v[p]) begin
            if (sc != 16'hFFFF) sc = sc + 16'd1;
          end else               k++;
          p++;
        end
        r = 0;
        while (!ab && r < ROWS && p < n) begin
          e_vec[p]  = pack_ctrl(1, 0, 0, 1, 0, 4'h0, 4'h0, r);
          e_scnt[p] = sc;
          if (rst_v[p])        ab = 1;
          else if (ready_v[p]) r++;
          p++;
        end
        if (!ab && r == ROWS && p < n) begin
          e_vec[p]  = pack_ctrl(1, 0, 0, 0, 1, 4'h0, 4'h0, 0);
          e_scnt[p] = sc;
          e_dones++;
          ab = rst_v[p];
          p++;
        end
        if (ab) sc = '0;
        c = p;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      start_v[i] = 0;
      stall_v[i] = 0;
      ready_v[i] = 1;
      rst_v[i]   = 0;
    end
  endtask

  // One reset cycle; returns at posedge+1, i.e. at the start of cycle 0.
  task automatic do_reset();
    rst = 1; start = 0; stall = 0; out_ready = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic run_cycles(input int n);
    o_dones      = 0;
    o_first_done = -1;
    for (int c = 0; c < n; c++) begin
      start     = start_v[c];
      stall     = stall_v[c];
      out_ready = ready_v[c];
      rst       = rst_v[c];
      @(negedge clk);
      o_vec[c]  = {busy, acc_clear, pe_en, out_valid, done, a_rd_en, b_rd_en, out_row};
      o_addr[c] = {a_rd_addr, b_rd_addr};
`ifdef STALL_CNT_EN
      o_scnt[c] = stall_cycles;
`else
      o_scnt[c] = '0;
`endif
      if (done) begin
        o_dones++;
        if (o_first_done < 0) o_first_done = c;
      end
      @(posedge clk); #1;
    end
    rst = 0; start = 0; stall = 0; out_ready = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1; start = 1; stall = 1; out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_cnt++;
    if ({busy, acc_clear, pe_en, out_valid, done, a_rd_en, b_rd_en, out_row} !== 15'h0)
      $display("FAIL reset_ctrl: got %h expected 0",
               {busy, acc_clear, pe_en, out_valid, done, a_rd_en, b_rd_en, out_row});
    else pass_cnt++;
    check_cnt++;
    if ({a_rd_addr, b_rd_addr} !== 32'h0)
      $display("FAIL reset_addr: got %h expected 0", {a_rd_addr, b_rd_addr});
    else pass_cnt++;
`ifdef STALL_CNT_EN
    check_cnt++;
    if (stall_cycles !== 16'h0)
      $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
    rst = 0; start = 0; stall = 0;
  endtask

  task automatic test_basic();
    clear_stim();
    start_v[0] = 1;
    build_model(20);
    do_reset();
    run_cycles(20);
    for (int c = 0; c < 20; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c])
        $display("FAIL basic_ctrl cycle %0d: got %h expected %h", c, o_vec[c], e_vec[c]);
      else pass_cnt++;
      if (e_chk[c]) begin
        check_cnt++;
        if (o_addr[c] !== e_addr[c])
          $display("FAIL basic_addr cycle %0d: got %h expected %h", c, o_addr[c], e_addr[c]);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (o_first_done !== 16 || o_dones !== 1)
      $display("FAIL basic_done: got cycle %0d count %0d expected cycle 16 count 1",
               o_first_done, o_dones);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    clear_stim();
    start_v[0] = 1;
    for (int c = 4; c < 7; c++) stall_v[c] = 1;   // t=2 is issued in cycle 4
    build_model(24);
    do_reset();
    run_cycles(24);
    for (int c = 0; c < 24; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c])
        $display("FAIL stall_ctrl cycle %0d: got %h expected %h", c, o_vec[c], e_vec[c]);
      else pass_cnt++;
      if (e_chk[c]) begin
        check_cnt++;
        if (o_addr[c] !== e_addr[c])
          $display("FAIL stall_addr cycle %0d: got %h expected %h", c, o_addr[c], e_addr[c]);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (o_first_done !== 19)
      $display("FAIL stall_done: got cycle %0d expected 19", o_first_done);
    else pass_cnt++;
  endtask

  task automatic test_out_ready();
    clear_stim();
    start_v[0] = 1;
    ready_v[13] = 0;                             // out_row=1 is shown in cycle 13
    ready_v[14] = 0;
    build_model(22);
    do_reset();
    run_cycles(22);
    for (int c = 0; c < 22; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c])
        $display("FAIL ready_ctrl cycle %0d: got %h expected %h", c, o_vec[c], e_vec[c]);
      else pass_cnt++;
    end
    check_cnt++;
    if (o_first_done !== 18)
      $display("FAIL ready_done: got cycle %0d expected 18", o_first_done);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    clear_stim();
    for (int c = 0; c < 40; c++) start_v[c] = 1;
    build_model(40);
    do_reset();
    run_cycles(40);
    for (int c = 0; c < 40; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c])
        $display("FAIL held_ctrl cycle %0d: got %h expected %h", c, o_vec[c], e_vec[c]);
      else pass_cnt++;
    end
    check_cnt++;
    if (o_vec[18][13] !== 1'b1 || o_vec[17][14] !== 1'b0)
      $display("FAIL held_second_clear: got clr18=%b busy17=%b expected 1 0",
               o_vec[18][13], o_vec[17][14]);
    else pass_cnt++;
    check_cnt++;
    if (o_dones !== e_dones)
      $display("FAIL held_done_count: got %0d expected %0d", o_dones, e_dones);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_stim();
    start_v[0]  = 1;
    rst_v[7]    = 1;                             // t=5 of COMPUTE
    start_v[10] = 1;
    build_model(34);
    do_reset();
    run_cycles(34);
    for (int c = 0; c < 34; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c] || (e_chk[c] && o_addr[c] !== e_addr[c]))
        $display("FAIL rstmid cycle %0d: got %h/%h expected %h/%h",
                 c, o_vec[c], o_addr[c], e_vec[c], e_addr[c]);
      else pass_cnt++;
    end
    check_cnt++;
    if (o_first_done !== 26 || o_dones !== 1)
      $display("FAIL rstmid_done: got cycle %0d count %0d expected cycle 26 count 1",
               o_first_done, o_dones);
    else pass_cnt++;
  endtask

  task automatic test_stall_count();
    int stall_cyc [7] = '{3, 4, 6, 8, 9, 10, 11};
    clear_stim();
    start_v[0]  = 1;
    foreach (stall_cyc[i]) stall_v[stall_cyc[i]] = 1;
    start_v[26] = 1;
    build_model(30);
    do_reset();
    run_cycles(30);
    for (int c = 0; c < 30; c++) begin
      check_cnt++;
      if (o_vec[c] !== e_vec[c] || (e_chk[c] && o_addr[c] !== e_addr[c]))
        $display("FAIL scnt_ctrl cycle %0d: got %h/%h expected %h/%h",
                 c, o_vec[c], o_addr[c], e_vec[c], e_addr[c]);
      else pass_cnt++;
`ifdef STALL_CNT_EN
      check_cnt++;
      if (o_scnt[c] !== e_scnt[c])
        $display("FAIL scnt_value cycle %0d: got %0d expected %0d", c, o_scnt[c], e_scnt[c]);
      else pass_cnt++;
`endif
    end
    check_cnt++;
    if (o_first_done !== 23)
      $display("FAIL scnt_done: got cycle %0d expected 23", o_first_done);
    else pass_cnt++;
`ifdef STALL_CNT_EN
    check_cnt++;
    if (o_scnt[23] !== 16'd7 || o_scnt[27] !== 16'd0)
      $display("FAIL scnt_endpoints: got %0d/%0d expected 7/0", o_scnt[23], o_scnt[27]);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_stim();
      for (int c = 0; c < NMAX; c++) begin
        start_v[c] = ($urandom_range(99) < 30);
        stall_v[c] = ($urandom_range(99) < 30);
        ready_v[c] = ($urandom_range(99) < 70);
        rst_v[c]   = ($urandom_range(99) < 2);
      end
      start_v[0] = 1;
      rst_v[0]   = 0;
      build_model(NMAX);
      do_reset();
      run_cycles(NMAX);
      for (int c = 0; c < NMAX; c++) begin
        check_cnt++;
        if (o_vec[c] !== e_vec[c] || (e_chk[c] && o_addr[c] !== e_addr[c]))
          $display("FAIL random it %0d cycle %0d: got %h/%h expected %h/%h",
                   it, c, o_vec[c], o_addr[c], e_vec[c], e_addr[c]);
        else pass_cnt++;
`ifdef STALL_CNT_EN
        check_cnt++;
        if (o_scnt[c] !== e_scnt[c])
          $display("FAIL random_scnt it %0d cycle %0d: got %0d expected %0d",
                   it, c, o_scnt[c], e_scnt[c]);
        else pass_cnt++;
`endif
      end
      check_cnt++;
      if (o_dones !== e_dones)
        $display("FAIL random_done_count it %0d: got %0d expected %0d", it, o_dones, e_dones);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; out_ready = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_stall();
    test_out_ready();
    test_start_held();
    test_reset_mid();
    test_stall_count();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
Sequences one matrix-multiply tile through the ROW_NUM x COL_NUM output-stationary systolic array. Accepts a start command, clears accumulators, and drives skewed read enables/addresses into the A (row) and B (column) operand buffers. Waits for the wavefront to drain, then unloads results row by row over a ready/valid port. Sits between the top-level job control and the array/operand buffers.

Parameters:
ROW_NUM, 4, array rows (A operand streams)
COL_NUM, 4, array columns (B operand streams)
K_DEPTH, 4, inner dimension; MACs per PE per tile
ADDR_W, 4, operand buffer address width; must satisfy 2^ADDR_W >= K_DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  tile request; sampled only in IDLE
stall  in  1  operand buffers not ready; freezes COMPUTE
busy  out  1  high in any state except IDLE
acc_clear  out  1  one-cycle accumulator clear pulse to array
pe_en  out  1  array MAC/shift enable
a_rd_en  out  ROW_NUM  per-row A buffer read enable
a_rd_addr  out  ROW_NUM*ADDR_W  per-row A address; row r at bits [r*ADDR_W +: ADDR_W]
b_rd_en  out  COL_NUM  per-column B buffer read enable
b_rd_addr  out  COL_NUM*ADDR_W  per-column B address, same packing
out_valid  out  1  result row available
out_row  out  clog2(ROW_NUM)  row index being unloaded
out_ready  in  1  downstream accepts result row
done  out  1  one-cycle pulse at tile completion

Behaviour:
- States: IDLE, CLEAR, COMPUTE, OUTPUT, DONE. Registered outputs, Moore style.
- Reset: state=IDLE; all outputs 0; counters 0. Reset mid-operation aborts the tile immediately with no done pulse.
- IDLE: start=1 -> CLEAR. start is ignored while busy; no queuing.
- CLEAR: acc_clear=1 for exactly one cycle -> COMPUTE with t=0.
- COMPUTE: cycle counter t runs 0..T_LAST, where T_LAST = K_DEPTH+ROW_NUM+COL_NUM-3.
  - Row r: a_rd_en[r]=1 iff r <= t < r+K_DEPTH; a_rd_addr_r = t-r when enabled, else 0.
  - Column c: the same rule with c.
  - pe_en=1 on every non-stalled COMPUTE cycle.
  - stall=1: t holds, and all rd_en bits and pe_en are 0 in that cycle. Addresses hold their value. The schedule resumes unchanged when stall returns to 0.
  - Non-stalled cycle with t==T_LAST -> OUTPUT with out_row=0.
- OUTPUT: out_valid=1, with out_row starting at 0. The row advances only on out_valid&&out_ready. A transfer on out_row==ROW_NUM-1 -> DONE. When out_ready=0, out_valid and out_row hold.
- DONE: done=1 for one cycle, busy still 1 -> IDLE. start in the DONE cycle is ignored.
- Default latency, no stall, out_ready=1: start sampled at edge N; CLEAR in cycle N+1; COMPUTE N+2..N+11 (10 cycles); OUTPUT N+12..N+15; DONE N+16; IDLE N+17.
- Width rules: t is wide enough for T_LAST. The address subtraction is never negative when enabled, and it truncates to ADDR_W.

Optional Feature:
Macro STALL_CNT_EN. When defined, adds output stall_cycles [15:0]:
- Cleared in CLEAR.
- Increments on each COMPUTE cycle with stall=1, saturating at 16'hFFFF.
- Holds its value after DONE until the next tile's CLEAR. Reset sets it to 0.
When undefined, the port and its counter are absent and behaviour is otherwise identical.

Test Plan:
- Defaults, start pulse at cycle 0, stall=0, out_ready=1 -> acc_clear at cycle 1; a_rd_en=4'b0001 at cycle 2; a_rd_en[3] high cycles 5..8 with addr 0..3; out_valid cycles 12..15 with out_row 0,1,2,3; done at cycle 16 only.
- stall=1 for 3 cycles at t=2 -> rd_en and pe_en are 0 for those cycles; t=2 addresses re-issue afterwards; done is delayed exactly 3 cycles (cycle 19).
- out_ready=0 for 2 cycles while out_row=1 -> out_row holds at 1 with out_valid=1; done is delayed 2 cycles.
- start held high through the whole tile -> exactly one tile and one done pulse. A second tile begins only because start is still high in IDLE (CLEAR at cycle 18).
- rst asserted at t=5 of COMPUTE -> next cycle: IDLE, all outputs 0, no done pulse; a fresh start runs a full tile normally.
- STALL_CNT_EN defined, 7 stall cycles in COMPUTE -> stall_cycles=7 at done; it is cleared to 0 in the next tile's CLEAR.
